fetch_unit: RTL and testbench

Instruction-fetch stage of the 5-stage core. It sits directly upstream of the hazard unit's IF/ID control and owns the PC register, the instruction-memory request/response handshake, a 2-entry fetch queue, and the IF/ID pipeline register. It consumes `if_dr_en` and `if_dr_clear` from the hazard unit and the taken-branch/jump redirect from EX. It delivers `if_dr_*` to decode.

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fetch_unit: PC, single-outstanding imem handshake, 2-entry FQ, IF/ID reg  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_dr_en,
  input  logic        if_dr_clear,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_dr_valid,
  output logic [31:0] if_dr_instr,
  output logic [31:0] if_dr_pc,
  output logic [31:0] if_dr_pc4
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        os_q, os_d;
  logic        kill_q, kill_d;
  logic [63:0] fq_q [2];
  logic [63:0] fq_d [2];
  logic [1:0]  cnt_q, cnt_d;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] idpc_q, idpc_d;

  logic        w_push;
  logic        w_pop;
  logic        w_gnt;
  logic        w_idx;
  logic [1:0]  w_cnt_after;

  assign imem_addr   = pc_q & ~32'd3;
  assign if_dr_valid = valid_q;
  assign if_dr_instr = instr_q;
  assign if_dr_pc    = idpc_q;
  assign if_dr_pc4   = idpc_q + 32'd4;

  always_comb begin
    w_push = imem_rvalid && os_q && !kill_q && !redirect;
    w_pop  = !redirect && !if_dr_clear && if_dr_en && (cnt_q != 2'd0);
    if (redirect) w_cnt_after = 2'd0;
    else          w_cnt_after = cnt_q + {1'b0, w_push} - {1'b0, w_pop};
    // Issue only if the eventual response is guaranteed a free FQ slot.
    imem_req = !rst && !redirect && (!os_q || imem_rvalid) && (w_cnt_after < 2'd2);
    w_gnt    = imem_req && imem_gnt;
    // Slot the incoming response lands in, after any head pop shifts the queue.
    w_idx    = w_pop ? (cnt_q == 2'd2) : (cnt_q == 2'd1);
  end

  always_comb begin
    pc_d     = pc_q;
    req_pc_d = req_pc_q;
    os_d     = os_q;
    kill_d   = kill_q;
    if (redirect)   pc_d = redirect_pc & ~32'd3;
    else if (w_gnt) pc_d = pc_q + 32'd4;
    if (w_gnt) req_pc_d = imem_addr;
    if (w_gnt)            os_d = 1'b1;
    else if (imem_rvalid) os_d = 1'b0;
    // A killed request stays in flight; its response is discarded on arrival.
    if (w_gnt)                 kill_d = 1'b0;
    else if (redirect && os_d) kill_d = 1'b1;
  end

  always_comb begin
    fq_d  = fq_q;
    cnt_d = w_cnt_after;
    if (w_pop)  fq_d[0] = fq_q[1];
    if (w_push) fq_d[w_idx] = {imem_rdata, req_pc_q};
  end

  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    idpc_d  = idpc_q;
    if (redirect || if_dr_clear) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (if_dr_en) begin
      if (cnt_q != 2'd0) begin
        valid_d = 1'b1;
        instr_d = fq_q[0][63:32];
        idpc_d  = fq_q[0][31:0];
      end else begin
        valid_d = 1'b0;
        instr_d = NOP_INSTR;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      req_pc_q <= 32'd0;
      os_q     <= 1'b0;
      kill_q   <= 1'b0;
      fq_q[0]  <= 64'd0;
      fq_q[1]  <= 64'd0;
      cnt_q    <= 2'd0;
      valid_q  <= 1'b0;
      instr_q  <= NOP_INSTR;
      idpc_q   <= RESET_PC;
    end else begin
      pc_q     <= pc_d;
      req_pc_q <= req_pc_d;
      os_q     <= os_d;
      kill_q   <= kill_d;
      fq_q[0]  <= fq_d[0];
      fq_q[1]  <= fq_d[1];
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
      instr_q  <= instr_d;
      idpc_q   <= idpc_d;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rvalid && !os_q));
      assert (!(w_push && !w_pop && cnt_q == 2'd2));
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fetch_unit: directed self-checking bench for fetch_unit                |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_dr_en = 1'b0;
  logic        if_dr_clear = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        if_dr_valid;
  logic [31:0] if_dr_instr, if_dr_pc, if_dr_pc4;

  logic        rvalid2 = 1'b0;
  logic [31:0] rdata2 = 32'd0;
  logic        req2, valid2;
  logic [31:0] addr2, instr2, pc2, pc4_2;

  int checks = 0;
  int errors = 0;

  int          lat = 1;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  int          wait_cnt = 0;
  logic        s_req = 1'b0, s_gnt = 1'b0, s_req2 = 1'b0;
  logic [31:0] s_addr = 32'd0, s_addr2 = 32'd0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .if_dr_en(if_dr_en), .if_dr_clear(if_dr_clear),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_dr_valid(if_dr_valid), .if_dr_instr(if_dr_instr),
    .if_dr_pc(if_dr_pc), .if_dr_pc4(if_dr_pc4)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .if_dr_en(1'b1), .if_dr_clear(1'b0),
    .redirect(1'b0), .redirect_pc(32'd0),
    .imem_req(req2), .imem_addr(addr2), .imem_gnt(1'b1),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .if_dr_valid(valid2), .if_dr_instr(instr2),
    .if_dr_pc(pc2), .if_dr_pc4(pc4_2)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // One cycle: controls are already set; sample the request mid-cycle, then
  // move to the next negedge and drive the memory responses for that cycle.
  task automatic tick();
    #1;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_gnt   = imem_req && imem_gnt;
    s_req2  = req2;
    s_addr2 = addr2;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    if (s_gnt) begin
      pend      = 1'b1;
      pend_addr = s_addr;
      wait_cnt  = lat;
    end
    if (pend) begin
      wait_cnt = wait_cnt - 1;
      if (wait_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem(pend_addr);
        pend        = 1'b0;
      end
    end
    rvalid2 = s_req2;
    rdata2  = mem(s_addr2);
  endtask

  task automatic do_reset(input int k);
    rst = 1'b1;
    if_dr_en = 1'b0; if_dr_clear = 1'b0; redirect = 1'b0;
    pend = 1'b0; imem_rvalid = 1'b0; rvalid2 = 1'b0;
    lat = k;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (if_dr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", if_dr_valid); end
    checks++; if (if_dr_instr !== 32'h13) begin errors++; $display("FAIL reset_instr: got %h expected 00000013", if_dr_instr); end
    checks++; if (if_dr_pc !== 32'h0 || if_dr_pc4 !== 32'h4) begin errors++; $display("FAIL reset_pc: got %h/%h expected 0/4", if_dr_pc, if_dr_pc4); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (pc2 !== 32'hFFFF_FFF8 || pc4_2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL reset_pc_wrap: got %h/%h expected fffffff8/fffffffc", pc2, pc4_2); end
  endtask

  task automatic test_free_run();
    logic [31:0] epc;
    do_reset(1);
    if_dr_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (s_req !== 1'b1 || s_addr !== 32'(4 * c)) begin errors++; $display("FAIL run_req c%0d: got req=%b addr=%h expected 1/%h", c, s_req, s_addr, 32'(4 * c)); end
      if (c < 2) begin
        checks++; if (if_dr_valid !== 1'b0) begin errors++; $display("FAIL run_latency c%0d: got valid=%b expected 0", c, if_dr_valid); end
      end else begin
        epc = 32'(4 * (c - 2));
        checks++;
        if (if_dr_valid !== 1'b1 || if_dr_pc !== epc || if_dr_instr !== mem(epc) || if_dr_pc4 !== epc + 32'd4) begin
          errors++; $display("FAIL run_ifid c%0d: got v=%b pc=%h i=%h pc4=%h expected 1/%h/%h/%h", c, if_dr_valid, if_dr_pc, if_dr_instr, if_dr_pc4, epc, mem(epc), epc + 32'd4);
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] epc;
    if_dr_en = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL stall_req c%0d: got %b expected 0", c, s_req); end
      checks++; if (if_dr_valid !== 1'b1 || if_dr_pc !== 32'd20) begin errors++; $display("FAIL stall_hold c%0d: got v=%b pc=%h expected 1/00000014", c, if_dr_valid, if_dr_pc); end
    end
    if_dr_en = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      if (j == 0) begin
        checks++; if (s_req !== 1'b1 || s_addr !== 32'd32) begin errors++; $display("FAIL release_req: got %b/%h expected 1/00000020", s_req, s_addr); end
      end
      epc = 32'(24 + 4 * j);
      checks++; if (if_dr_valid !== 1'b1 || if_dr_pc !== epc || if_dr_instr !== mem(epc)) begin errors++; $display("FAIL release_ifid j%0d: got v=%b pc=%h i=%h expected 1/%h/%h", j, if_dr_valid, if_dr_pc, if_dr_instr, epc, mem(epc)); end
    end
  endtask

  task automatic test_async_reset();
    rst = 1'b1;
    #1;
    checks++; if (if_dr_valid !== 1'b0 || if_dr_pc !== 32'h0 || if_dr_pc4 !== 32'h4 || if_dr_instr !== 32'h13) begin
      errors++; $display("FAIL async_reset: got v=%b pc=%h pc4=%h i=%h expected 0/0/4/13", if_dr_valid, if_dr_pc, if_dr_pc4, if_dr_instr);
    end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL async_reset_req: got %b expected 0", imem_req); end
  endtask

  task automatic test_redirect_outstanding();
    do_reset(3);
    if_dr_en = 1'b1;
    for (int c = 0; c <= 12; c++) tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h10) begin errors++; $display("FAIL k3_req10: got %b/%h expected 1/00000010", s_req, s_addr); end
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL redir_req: got %b expected 0", s_req); end
    checks++; if (if_dr_valid !== 1'b0 || if_dr_instr !== 32'h13 || if_dr_pc !== 32'h8) begin errors++; $display("FAIL redir_bubble: got v=%b i=%h pc=%h expected 0/13/8", if_dr_valid, if_dr_instr, if_dr_pc); end
    tick();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL kill_wait_req: got %b expected 0", s_req); end
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h100) begin errors++; $display("FAIL kill_reissue: got %b/%h expected 1/00000100", s_req, s_addr); end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++; if (if_dr_valid !== 1'b0) begin errors++; $display("FAIL kill_drop c%0d: got valid=%b pc=%h expected 0", c, if_dr_valid, if_dr_pc); end
    end
    tick();
    checks++; if (if_dr_valid !== 1'b1 || if_dr_pc !== 32'h100 || if_dr_instr !== mem(32'h100)) begin errors++; $display("FAIL redir_first: got v=%b pc=%h i=%h expected 1/100/%h", if_dr_valid, if_dr_pc, if_dr_instr, mem(32'h100)); end
  endtask

  task automatic test_redirect_rvalid();
    do_reset(1);
    if_dr_en = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    checks++; if (s_req !== 1'b0 || if_dr_valid !== 1'b0) begin errors++; $display("FAIL rv_redir: got req=%b v=%b expected 0/0", s_req, if_dr_valid); end
    tick();
    checks++; if (s_req !== 1'b1 || s_addr !== 32'h200) begin errors++; $display("FAIL rv_next_req: got %b/%h expected 1/00000200", s_req, s_addr); end
    checks++; if (if_dr_valid !== 1'b0) begin errors++; $display("FAIL rv_dropped: got valid=%b pc=%h expected 0", if_dr_valid, if_dr_pc); end
    tick();
    tick();
    checks++; if (if_dr_valid !== 1'b1 || if_dr_pc !== 32'h200 || if_dr_instr !== mem(32'h200)) begin errors++; $display("FAIL rv_first: got v=%b pc=%h i=%h expected 1/200/%h", if_dr_valid, if_dr_pc, if_dr_instr, mem(32'h200)); end
  endtask

  task automatic test_clear();
    do_reset(1);
    if_dr_en = 1'b0;
    tick(); tick(); tick();
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL clr_full_req: got %b expected 0", s_req); end
    if_dr_en = 1'b1;
    tick();
    checks++; if (if_dr_valid !== 1'b1 || if_dr_pc !== 32'h0 || s_addr !== 32'h8) begin errors++; $display("FAIL clr_pop0: got v=%b pc=%h addr=%h expected 1/0/8", if_dr_valid, if_dr_pc, s_addr); end
    if_dr_en = 1'b0;
    tick();
    if_dr_clear = 1'b1; if_dr_en = 1'b1;
    tick();
    if_dr_clear = 1'b0;
    checks++; if (if_dr_valid !== 1'b0 || if_dr_instr !== 32'h13 || if_dr_pc !== 32'h0) begin errors++; $display("FAIL clr_bubble: got v=%b i=%h pc=%h expected 0/13/0", if_dr_valid, if_dr_instr, if_dr_pc); end
    checks++; if (s_req !== 1'b0) begin errors++; $display("FAIL clr_req: got %b expected 0", s_req); end
    tick();
    checks++; if (if_dr_valid !== 1'b1 || if_dr_pc !== 32'h4 || if_dr_instr !== mem(32'h4)) begin errors++; $display("FAIL clr_older: got v=%b pc=%h i=%h expected 1/4/%h", if_dr_valid, if_dr_pc, if_dr_instr, mem(32'h4)); end
    tick();
    checks++; if (if_dr_valid !== 1'b1 || if_dr_pc !== 32'h8) begin errors++; $display("FAIL clr_next: got v=%b pc=%h expected 1/8", if_dr_valid, if_dr_pc); end
  endtask

  task automatic test_wrap();
    do_reset(1);
    tick();
    checks++; if (s_req2 !== 1'b1 || s_addr2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_req0: got %b/%h expected 1/fffffff8", s_req2, s_addr2); end
    tick();
    checks++; if (s_addr2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_req1: got %h expected fffffffc", s_addr2); end
    tick();
    checks++; if (s_addr2 !== 32'h0) begin errors++; $display("FAIL wrap_req2: got %h expected 00000000", s_addr2); end
    checks++; if (valid2 !== 1'b1 || pc2 !== 32'hFFFF_FFF8 || pc4_2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_ifid0: got v=%b pc=%h pc4=%h expected 1/fffffff8/fffffffc", valid2, pc2, pc4_2); end
    tick();
    checks++; if (pc2 !== 32'hFFFF_FFFC || pc4_2 !== 32'h0 || instr2 !== mem(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_pc4: got pc=%h pc4=%h i=%h expected fffffffc/0/%h", pc2, pc4_2, instr2, mem(32'hFFFF_FFFC)); end
    tick();
    checks++; if (pc2 !== 32'h0 || instr2 !== mem(32'h0)) begin errors++; $display("FAIL wrap_zero: got pc=%h i=%h expected 0/%h", pc2, instr2, mem(32'h0)); end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_stall();
    test_async_reset();
    test_redirect_outstanding();
    test_redirect_rvalid();
    test_clear();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
